// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, fetch-entry type and address helper for the fetch unit
package fetch_pkg;

  localparam int          IMEM_AW      = 13;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_QDEPTH   = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  // Instruction memory is word addressed; drop the byte offset and keep IMEM_AW bits.
  function automatic logic [IMEM_AW-1:0] word_addr(input logic [31:0] byte_pc);
    return byte_pc[IMEM_AW+1:2];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch buffer, two pushes and zero to two pops per cycle
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  QDEPTH = DEF_QDEPTH,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       push_e1_i,
  input  fetch_entry_t       push_e2_i,
  input  logic [1:0]         deq_num_i,
  output logic [CW-1:0]      count_o,
  output logic [1:0]         valid_o,
  output fetch_entry_t       head1_o,
  output fetch_entry_t       head2_o
);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_p1, tail_p1;
  logic [CW-1:0] count_q, count_d;

  assign head_p1 = head_q + PW'(1);
  assign tail_p1 = tail_q + PW'(1);

  // Pointer and occupancy update; a flush wins over any push or pop in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deq_num_i);
      tail_d  = push_i ? tail_q + PW'(2) : tail_q;
      count_d = count_q + (push_i ? CW'(2) : CW'(0)) - CW'(deq_num_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[tail_q]  <= push_e1_i;
      mem_q[tail_p1] <= push_e2_i;
    end
  end

  assign head1_o = mem_q[head_q];
  assign head2_o = mem_q[head_p1];
  assign valid_o = {count_q >= CW'(2), count_q != '0};
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - dual-slot instruction fetch with redirect and fetch queue; FETCH_PERF_CNT_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          QDEPTH   = DEF_QDEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr1,
  output logic [IMEM_AW-1:0] imem_addr2,
  input  logic [31:0]        imem_ir1,
  input  logic [31:0]        imem_ir2,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [1:0]         out_valid,
  output logic [31:0]        out_pc1,
  output logic [31:0]        out_pc2,
  output logic [31:0]        out_ir1,
  output logic [31:0]        out_ir2,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubble,
`endif
  input  logic [1:0]         deq_num
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          req_valid_q, req_valid_d;
  logic [CW-1:0] q_count;
  logic [CW:0]   occ_claim;
  logic          issue;
  logic          push;
  fetch_entry_t  push_e1, push_e2, head1, head2;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Issue only when the queue can absorb this pair plus any pair already in flight.
  always_comb begin
    occ_claim   = {1'b0, q_count} + (req_valid_q ? (CW+1)'(2) : (CW+1)'(0));
    issue       = !redirect_valid && (occ_claim <= (CW+1)'(QDEPTH - 2));
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = 1'b0;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      pc_d        = pc_q + 32'd8;
      req_valid_d = 1'b1;
      req_pc_d    = pc_q;
    end
  end

  // PC and in-flight request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign imem_addr1 = word_addr(pc_q);
  assign imem_addr2 = word_addr(pc_q) + IMEM_AW'(1);

  // A redirect discards the response returning this cycle along with the queue.
  assign push    = req_valid_q && !redirect_valid;
  assign push_e1 = '{pc: req_pc_q,         ir: imem_ir1};
  assign push_e2 = '{pc: req_pc_q + 32'd4, ir: imem_ir2};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_valid),
    .push_i    (push),
    .push_e1_i (push_e1),
    .push_e2_i (push_e2),
    .deq_num_i (deq_num),
    .count_o   (q_count),
    .valid_o   (out_valid),
    .head1_o   (head1),
    .head2_o   (head2)
  );

  assign out_pc1 = head1.pc;
  assign out_ir1 = head1.ir;
  assign out_pc2 = head2.pc;
  assign out_ir2 = head2.ir;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_bubble_q;

  // Count pushed entries and idle cycles not caused by a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd2;
      end
      if ((out_valid == 2'b00) && !redirect_valid) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [12:0] imem_addr1, imem_addr2;
  logic [31:0] imem_ir1 = '0, imem_ir2 = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [1:0]  out_valid;
  logic [31:0] out_pc1, out_pc2, out_ir1, out_ir2;
  logic [1:0]  deq_num = 2'd0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubble;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr1     (imem_addr1),
    .imem_addr2     (imem_addr2),
    .imem_ir1       (imem_ir1),
    .imem_ir2       (imem_ir2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc1        (out_pc1),
    .out_pc2        (out_pc2),
    .out_ir1        (out_ir1),
    .out_ir2        (out_ir2),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_bubble    (perf_bubble),
`endif
    .deq_num        (deq_num)
  );

  always #5 clk = ~clk;

  // Memory word n holds the value n.
  always @(posedge clk) begin
    imem_ir1 <= {19'd0, imem_addr1};
    imem_ir2 <= {19'd0, imem_addr2};
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gen_pc;
  int          checks = 0;
  int          failures = 0;
  int          deq_mode = 0;
  int          popped = 0;

  // Reference rule: the fetch stream is consecutive words from the last restart point.
  function automatic logic [31:0] model_ir(input logic [31:0] pc);
    return {19'd0, pc[14:2]};
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, ir: model_ir(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] start_pc);
    exp_q.delete();
    gen_pc = {start_pc[31:2], 2'b00};
    top_up();
  endtask

  function automatic logic [1:0] pick_deq();
    int avail;
    avail = out_valid[1] ? 2 : (out_valid[0] ? 1 : 0);
    case (deq_mode)
      0:       return 2'd0;
      1:       return 2'(avail);
      default: return 2'($urandom_range(avail, 0));
    endcase
  endfunction

  // Advance into the next cycle and drive fresh inputs.
  task automatic step();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    top_up();
    deq_num = pick_deq();
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    restart(tgt);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n          = 1'b0;
    deq_num        = 2'd0;
    redirect_valid = 1'b0;
    restart(RESET_PC);
    #1;
    check_eq("async_reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    deq_num = pick_deq();
  endtask

  // Monitor: compare visible head entries against the scoreboard and retire consumed ones.
  always @(negedge clk) begin
    if (rst_n && !redirect_valid) begin
      if (out_valid == 2'b10) begin
        check_eq("out_valid_legal", 32'(out_valid), 32'd3);
      end
      if (out_valid[0]) begin
        if (exp_q.size() < 2) begin
          check_eq("scoreboard_depth", exp_q.size(), 32'd2);
        end else begin
          check_eq("head_pc1", out_pc1, exp_q[0].pc);
          check_eq("head_ir1", out_ir1, exp_q[0].ir);
          if (out_valid[1]) begin
            check_eq("head_pc2", out_pc2, exp_q[1].pc);
            check_eq("head_ir2", out_ir2, exp_q[1].ir);
          end
          for (int i = 0; i < int'(deq_num); i++) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    gen_pc = RESET_PC;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);

    // Reset release, full-rate dequeue, sequential stream with no gaps.
    deq_mode = 1;
    #1;
    rst_n = 1'b1;
    restart(RESET_PC);
    deq_num = pick_deq();
    @(negedge clk);
    check_eq("rel_c0_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rel_c1_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rel_c2_out_valid", 32'(out_valid), 32'd3);
    check_eq("rel_c2_pc1", out_pc1, RESET_PC);
    check_eq("rel_c2_ir1", out_ir1, model_ir(RESET_PC));
    check_eq("rel_c2_pc2", out_pc2, RESET_PC + 32'd4);
    check_eq("rel_c2_ir2", out_ir2, model_ir(RESET_PC + 32'd4));
    for (int c = 3; c < 24; c++) begin
      step();
`ifdef FETCH_PERF_CNT_EN
      if (c == 10) begin
        check_eq("perf_bubble", perf_bubble, 32'd2);
        check_eq("perf_fetched", perf_fetched, 32'd2 * (32'd10 - 32'd1));
      end
`endif
      @(negedge clk);
      check_eq("no_gap_out_valid", 32'(out_valid), 32'd3);
    end

    // No dequeue: the queue fills to QDEPTH and issue stops.
    deq_mode = 0;
    step();
    do_redirect(32'h0000_1000);
    repeat (12) step();
    @(negedge clk);
    check_eq("fill_out_valid", 32'(out_valid), 32'd3);
    check_eq("fill_stop_addr", 32'(imem_addr1), (32'h1000 + 32'(QDEPTH) * 32'd4) >> 2);
    repeat (3) step();
    @(negedge clk);
    check_eq("fill_hold_addr", 32'(imem_addr1), (32'h1000 + 32'(QDEPTH) * 32'd4) >> 2);
    deq_mode = 1;
    repeat (10) step();

    // Redirect with a full queue.
    deq_mode = 0;
    repeat (12) step();
    step();
    do_redirect(32'h0000_0104);
    step();
    @(negedge clk);
    check_eq("redir_t1_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("redir_t2_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("redir_t3_out_valid", 32'(out_valid), 32'd3);
    check_eq("redir_t3_pc1", out_pc1, 32'h0000_0104);
    check_eq("redir_t3_ir1", out_ir1, 32'h0000_0041);
    check_eq("redir_t3_pc2", out_pc2, 32'h0000_0108);
    check_eq("redir_t3_ir2", out_ir2, 32'h0000_0042);

    // Word-address wrap at the top of instruction memory.
    step();
    do_redirect(32'h0000_7FF8);
    step();
    @(negedge clk);
    check_eq("wrap_addr1", 32'(imem_addr1), 32'd8190);
    check_eq("wrap_addr2", 32'(imem_addr2), 32'd8191);
    step();
    @(negedge clk);
    check_eq("wrap_next_addr1", 32'(imem_addr1), 32'd0);
    check_eq("wrap_next_addr2", 32'(imem_addr2), 32'd1);
    deq_mode = 1;
    repeat (8) step();

    // Back-to-back redirects: the later target wins.
    step();
    do_redirect(32'h0000_0200);
    step();
    do_redirect(32'h0000_0400);
    @(negedge clk);
    check_eq("rr_t1_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rr_t2_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rr_t3_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check_eq("rr_t4_valid0", 32'(out_valid[0]), 32'd1);
    check_eq("rr_t4_pc1", out_pc1, 32'h0000_0400);
    repeat (6) step();

    // Randomized traffic with redirects, wrap-around targets and mid-run resets.
    deq_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      int r;
      step();
      r = int'($urandom_range(999, 0));
      if (r < 40) begin
        do_redirect($urandom);
      end else if (r < 45) begin
        do_redirect(32'hFFFF_FFE0 | ($urandom & 32'h1F));
      end else if (r < 47) begin
        apply_reset();
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (popped < 2000) begin
      failures++;
      $display("FAIL throughput actual=%0d required>=2000", popped);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
